// File: rtl/rtl_kernel_multi_ctrl.sv
// Kernel ap_ctrl sequencer: fans ap_start out to NUM_CH engines and folds their done pulses back.
// Define KERNEL_CTRL_CHAIN_EN for ap_ctrl_chain handshaking (ap_done held until ap_continue).
module rtl_kernel_multi_ctrl #(
    parameter int unsigned NUM_CH            = 4,
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_XFER_SIZE_WIDTH = 32,
    parameter int unsigned LP_DEFAULT_BYTES  = 16384,
    parameter int unsigned C_CYCLE_CNT_WIDTH = 48
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic                             ap_start,
    input  logic                             ap_continue,
    output logic                             ap_idle,
    output logic                             ap_done,
    output logic                             ap_ready,
    input  logic [C_XFER_SIZE_WIDTH-1:0]     scalar_xfer_bytes,
    input  logic [NUM_CH-1:0]                scalar_ch_mask,
    input  logic [C_ADDR_WIDTH-1:0]          base_ptr,
    output logic [NUM_CH-1:0]                ch_start,
    output logic [NUM_CH*C_ADDR_WIDTH-1:0]   ch_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]     ch_xfer_bytes,
    input  logic [NUM_CH-1:0]                ch_done,
    output logic [C_CYCLE_CNT_WIDTH-1:0]     cycle_count,
    output logic                             err_empty_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [1:0]                     rst_sync;
    logic                           rst_n;
    logic                           ap_start_r;
    logic                           start_pulse;
    logic [NUM_CH-1:0]              mask_r;
    logic [NUM_CH-1:0]              done_r;
    logic [C_XFER_SIZE_WIDTH-1:0]   eff_size;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_sync <= '0;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign start_pulse = ap_start & ~ap_start_r;
    assign eff_size    = (scalar_xfer_bytes == '0) ? C_XFER_SIZE_WIDTH'(LP_DEFAULT_BYTES)
                                                   : scalar_xfer_bytes;

`ifdef KERNEL_CTRL_CHAIN_EN
    logic done_entry;

    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) done_entry <= 1'b0;
        else        done_entry <= (state_next == DONE) && (state != DONE);
    end
`else
    logic unused_continue;
    assign unused_continue = ap_continue;
`endif

    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ch_start   = '0;
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse)
                    state_next = (scalar_ch_mask == '0) ? DONE : LAUNCH;
            end
            LAUNCH: begin
                ch_start   = mask_r;
                state_next = RUN;
            end
            RUN: begin
                if ((done_r | (ch_done & mask_r)) == mask_r)
                    state_next = DONE;
            end
            DONE: begin
                ap_done = 1'b1;
`ifdef KERNEL_CTRL_CHAIN_EN
                ap_ready = done_entry;
                if (ap_continue)
                    state_next = IDLE;
`else
                ap_ready   = 1'b1;
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) begin
            ap_start_r     <= 1'b0;
            mask_r         <= '0;
            done_r         <= '0;
            ch_addr        <= '0;
            ch_xfer_bytes  <= '0;
            cycle_count    <= '0;
            err_empty_mask <= 1'b0;
            ap_idle        <= 1'b1;
        end else begin
            ap_start_r <= ap_start;
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        mask_r         <= scalar_ch_mask;
                        ch_xfer_bytes  <= eff_size;
                        done_r         <= '0;
                        cycle_count    <= '0;
                        err_empty_mask <= (scalar_ch_mask == '0);
                        ap_idle        <= 1'b0;
                        // Channel offsets wrap silently at the address width.
                        for (int unsigned i = 0; i < NUM_CH; i++)
                            ch_addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH] <=
                                base_ptr + C_ADDR_WIDTH'(i) * C_ADDR_WIDTH'(eff_size);
                    end
                end
                LAUNCH, RUN: begin
                    done_r <= done_r | (ch_done & mask_r);
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + C_CYCLE_CNT_WIDTH'(1);
                end
                DONE: begin
                    if (state_next == IDLE)
                        ap_idle <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
